// File: rtl/cra_seq_adder.sv
// Multi-cycle carry-ripple adder: K bits per clock, carry held between chunks.
// Optional subtract mode with signed overflow under macro CRA_SUB_EN.

module cra_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module cra_seq_adder #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef CRA_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
`ifdef CRA_SUB_EN
    output logic         ovf,
`endif
    output logic         cout
);
    localparam int NC = N / K;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_s;
    logic            r_carry;
    logic            r_cout;
    logic [IW-1:0]   r_idx;
`ifdef CRA_SUB_EN
    logic            r_ovf;
`endif

    logic [K-1:0]    w_ca;
    logic [K-1:0]    w_cb;
    logic [K-1:0]    w_sum;
    logic [K:0]      w_c;
    logic            w_last;
    logic            w_accept;

    assign w_ca     = r_a[r_idx*K +: K];
    assign w_cb     = r_b[r_idx*K +: K];
    assign w_c[0]   = r_carry;
    assign w_last   = (r_idx == IW'(NC - 1));
    assign w_accept = (r_state != RUN) && start;

    // One K-bit ripple chunk, reused for every chunk index.
    for (genvar g = 0; g < K; g++) begin : g_fa
        cra_full_adder u_fa (
            .i_a (w_ca[g]),
            .i_b (w_cb[g]),
            .i_c (w_c[g]),
            .o_s (w_sum[g]),
            .o_c (w_c[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: w_next = start ? RUN : IDLE;
            RUN:        w_next = w_last ? DONE : RUN;
            default:    w_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Operand capture and chunk-by-chunk accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
`ifdef CRA_SUB_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_s     <= '0;
            r_idx   <= '0;
`ifdef CRA_SUB_EN
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
        end else if (r_state == RUN) begin
            r_s[r_idx*K +: K] <= w_sum;
            r_carry           <= w_c[K];
            r_idx             <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) begin
                r_cout <= w_c[K];
`ifdef CRA_SUB_EN
                r_ovf  <= w_c[K] ^ w_c[K-1];
`endif
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
`ifdef CRA_SUB_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_cra_seq_adder.sv
// Self-checking bench for cra_seq_adder with directed and random operations.
// Build with CRA_SUB_EN defined to exercise subtract mode.

module tb_cra_seq_adder;
    localparam int N  = 16;
    localparam int K  = 4;
    localparam int NC = N / K;
`ifdef CRA_SUB_EN
    localparam bit SUBEN = 1'b1;
`else
    localparam bit SUBEN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int compared;
    int mismatched;

    cra_seq_adder #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cin   (cin),
        .a     (a),
        .b     (b),
`ifdef CRA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
`ifdef CRA_SUB_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

`ifndef CRA_SUB_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, {ovf, cout, s}.
    function automatic logic [N+1:0] model(input logic [N-1:0] ma,
                                           input logic [N-1:0] mb,
                                           input logic mcin,
                                           input logic msub);
        logic [N-1:0] bb;
        logic         c0;
        logic [N:0]   r;
        logic         v;
        bb = msub ? ~mb : mb;
        c0 = msub ? 1'b1 : mcin;
        r  = {1'b0, ma} + {1'b0, bb} + {{N{1'b0}}, c0};
        v  = (ma[N-1] == bb[N-1]) && (r[N-1] != ma[N-1]);
        return {v, r};
    endfunction

    task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic tcin, input logic tsub, input bit hold);
        logic [N+1:0] m;
        m     = model(ta, tb, tcin, tsub & SUBEN);
        a     = ta;
        b     = tb;
        cin   = tcin;
        sub   = tsub & SUBEN;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("s_clear", 32'(s), 32'h0);
        for (int i = 1; i <= NC; i++) begin
            check("run_busy", 32'(busy), 32'h1);
            check("run_done", 32'(done), 32'h0);
            if (hold && i == 2) begin
                a   = N'($urandom);
                b   = N'($urandom);
                cin = ~cin;
            end
            tick();
        end
        start = 1'b0;
        check("done", 32'(done), 32'h1);
        check("done_busy", 32'(busy), 32'h0);
        check("sum", 32'(s), 32'(m[N-1:0]));
        check("cout", 32'(cout), 32'(m[N]));
        check("ovf", 32'(ovf), 32'(SUBEN ? m[N+1] : 1'b0));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_s", 32'(s), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_done", 32'(done), 32'h0);
        check("hold_s", 32'(s), 32'h0000);
        check("hold_cout", 32'(cout), 32'h1);

        op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        tick();
        check("one_done", 32'(done), 32'h0);
        check("one_busy", 32'(busy), 32'h0);

        op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
        op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        tick();

        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_s", 32'(s), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_done", 32'(done), 32'h0);
        end
        op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
        tick();

        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_start_busy", 32'(busy), 32'h0);
        tick();
        check("rst_start_busy2", 32'(busy), 32'h0);
        check("rst_start_done", 32'(done), 32'h0);
        check("rst_start_s", 32'(s), 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("rel_busy", 32'(busy), 32'h0);

        op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        tick();

        for (int n = 0; n < 24; n++) begin
            op(N'($urandom), N'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
